adc_line_sensor_reader: RTL and testbench

ADC_LINE_SENSOR_READER -- requirements
Module: adc_line_sensor_reader

---
 rtl/sm_bot_pkg.sv | 54 +++++
 rtl/adc_clk_div.sv | 30 +++
 rtl/adc_line_sensor_reader.sv | 153 +++++++++++++++
 tb/tb_adc_line_sensor_reader.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_bot_pkg.sv
// Shared types and constants for the line-sensor ADC reader.
// Latency: none, declarations and pure helper functions only.
// Backpressure: none.
package sm_bot_pkg;

    // Frame sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        GAP
    } adc_state_t;

    // ADC input channel wired to each line sensor.
    localparam logic [1:0] CH_LEFT   = 2'd0;
    localparam logic [1:0] CH_CENTRE = 2'd1;
    localparam logic [1:0] CH_RIGHT  = 2'd2;

    // Full-scale reference of the ADC in millivolts.
    localparam int ADC_VREF_MV = 3300;

    // One frame is 16 SCK periods; the first 4 carry no conversion data.
    localparam int FRAME_BITS     = 16;
    localparam int FIRST_DATA_BIT = 4;

    // Round-robin over the three sensor channels.
    function automatic logic [1:0] next_ch(input logic [1:0] ch);
        return (ch == CH_RIGHT) ? CH_LEFT : ch + 2'd1;
    endfunction

    // Address bit presented on DIN for bit slot k: ADD2..ADD0 in slots 2..4.
    function automatic logic addr_bit(input logic [3:0] k, input logic [1:0] ch);
        logic [2:0] addr;
        logic       b;
        addr = {1'b0, ch};
        b    = 1'b0;
        case (k)
            4'd2:    b = addr[2];
            4'd3:    b = addr[1];
            4'd4:    b = addr[0];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    // Raw 12-bit code to millivolts, truncating; full scale maps to 3299.
    function automatic logic [11:0] scale_mv(input logic [11:0] code);
        logic [23:0] prod;
        prod = {12'd0, code} * 24'(ADC_VREF_MV);
        return prod[23:12];
    endfunction

endpackage

// File: rtl/adc_clk_div.sv
// Free-running SCK half-period tick generator: one-clock tick every CLK_DIV clocks.
// Latency: first tick CLK_DIV clocks after reset release.
// Backpressure: none, the tick cadence is fixed.
module adc_clk_div #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // Count 0..CLK_DIV-1 and wrap; the wrap clock is the tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/adc_line_sensor_reader.sv
// Scans ADC ch0..ch2 over SPI round-robin into in0..in2; data_valid marks a complete scan.
// Latency: result written one clock after the last SCK rising edge of a frame.
// Backpressure: none; build option ADC_MV_SCALE_EN stores millivolts instead of raw codes.
module adc_line_sensor_reader
    import sm_bot_pkg::*;
#(
    parameter int CLK_DIV   = 25,
    parameter int FRAME_GAP = 2
) (
    input  logic        clk_50M,
    input  logic        reset_n,
    input  logic        adc_dout,
    output logic        adc_cs_n,
    output logic        adc_sck,
    output logic        adc_din,
    output logic [11:0] in0,
    output logic [11:0] in1,
    output logic [11:0] in2,
    output logic        data_valid
);

    localparam int            GW       = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(FRAME_GAP - 1);

    adc_state_t    state;
    logic          tick;
    logic [3:0]    bit_idx;
    logic [GW-1:0] gap_cnt;
    logic [11:0]   shreg;
    logic          wr_pend;
    logic [1:0]    ptr;       // channel whose conversion arrives in the current frame
    logic [1:0]    addr_ch;   // channel requested during the current frame
    logic          got0;
    logic          got1;
    logic [11:0]   result;

    adc_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk   (clk_50M),
        .rst_n (reset_n),
        .tick  (tick)
    );

    // The ADC returns the channel requested one frame earlier.
    assign addr_ch = next_ch(ptr);

`ifdef ADC_MV_SCALE_EN
    assign result = scale_mv(shreg);
`else
    assign result = shreg;
`endif

    // Frame sequencer: every tick moves CS/SCK/DIN by one half-period.
    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            adc_cs_n <= 1'b1;
            adc_sck  <= 1'b1;
            adc_din  <= 1'b0;
            bit_idx  <= '0;
            gap_cnt  <= '0;
            shreg    <= '0;
            wr_pend  <= 1'b0;
        end else begin
            wr_pend <= 1'b0;
            if (tick) begin
                case (state)
                    IDLE: begin
                        state    <= CS_SETUP;
                        adc_cs_n <= 1'b0;
                    end
                    CS_SETUP: begin
                        // First falling edge opens bit slot 0, which carries no address.
                        state   <= SHIFT;
                        adc_sck <= 1'b0;
                        adc_din <= 1'b0;
                        bit_idx <= '0;
                    end
                    SHIFT: begin
                        adc_sck <= ~adc_sck;
                        if (adc_sck) begin
                            adc_din <= addr_bit(bit_idx, addr_ch);
                        end else begin
                            if (bit_idx >= 4'(FIRST_DATA_BIT)) begin
                                shreg <= {shreg[10:0], adc_dout};
                            end
                            if (bit_idx == 4'(FRAME_BITS - 1)) begin
                                state   <= CS_HOLD;
                                wr_pend <= 1'b1;
                            end else begin
                                bit_idx <= bit_idx + 4'd1;
                            end
                        end
                    end
                    CS_HOLD: begin
                        state    <= GAP;
                        adc_cs_n <= 1'b1;
                        gap_cnt  <= '0;
                    end
                    GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            state    <= CS_SETUP;
                            adc_cs_n <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt + GW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Commit a finished word to its sensor register and flag completed scans.
    always_ff @(posedge clk_50M or negedge reset_n) begin
        if (!reset_n) begin
            in0        <= '0;
            in1        <= '0;
            in2        <= '0;
            data_valid <= 1'b0;
            ptr        <= CH_LEFT;
            got0       <= 1'b0;
            got1       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (wr_pend) begin
                case (ptr)
                    CH_LEFT: begin
                        in0  <= result;
                        got0 <= 1'b1;
                    end
                    CH_CENTRE: begin
                        in1  <= result;
                        got1 <= 1'b1;
                    end
                    CH_RIGHT: begin
                        in2 <= result;
                        if (got0 && got1) begin
                            data_valid <= 1'b1;
                            got0       <= 1'b0;
                            got1       <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
                ptr <= next_ch(ptr);
            end
        end
    end

endmodule

// File: tb/tb_adc_line_sensor_reader.sv
// Bench for adc_line_sensor_reader: ADC model, behavioural scoreboard, randomized codes.
// Latency: checks every clock after the DUT settles.
// Backpressure: none.
module tb_adc_line_sensor_reader;

    localparam int CLK_DIV   = 25;
    localparam int FRAME_GAP = 2;

`ifdef ADC_MV_SCALE_EN
    localparam int E_0E0 = 180;
    localparam int E_AAA = 2199;
    localparam int E_FFF = 3299;
    localparam int E_000 = 0;
    localparam int E_800 = 1650;
`else
    localparam int E_0E0 = 224;
    localparam int E_AAA = 2730;
    localparam int E_FFF = 4095;
    localparam int E_000 = 0;
    localparam int E_800 = 2048;
`endif

    logic        clk_50M  = 1'b0;
    logic        reset_n  = 1'b1;
    logic        adc_dout = 1'b0;
    logic        adc_cs_n;
    logic        adc_sck;
    logic        adc_din;
    logic [11:0] in0;
    logic [11:0] in1;
    logic [11:0] in2;
    logic        data_valid;

    int checks = 0;
    int errors = 0;

    // ADC stimulus state
    logic [11:0] codes [3];
    bit          lead_ones;
    int          adc_ch;
    int          adc_k;
    logic [2:0]  adc_addr;
    logic [11:0] frame_code;

    // Reference model state
    int          exp_in [3];
    bit          got0, got1, pend, dv_exp, gap_valid;
    int          pend_ch, pend_val, nframe, cur_ch, frames_done, dv_count, since;
    logic [2:0]  exp_addr;
    logic [4:0]  f0_din;
    logic        prev_cs, prev_sck, prev_din, prev_dv;
    logic [11:0] prev_in0, prev_in1;
    bit          cs_fell, cs_rose, sck_fell, sck_rose;

    adc_line_sensor_reader #(
        .CLK_DIV   (CLK_DIV),
        .FRAME_GAP (FRAME_GAP)
    ) dut (
        .clk_50M    (clk_50M),
        .reset_n    (reset_n),
        .adc_dout   (adc_dout),
        .adc_cs_n   (adc_cs_n),
        .adc_sck    (adc_sck),
        .adc_din    (adc_din),
        .in0        (in0),
        .in1        (in1),
        .in2        (in2),
        .data_valid (data_valid)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Value a sensor register must hold for a given ADC code.
    function automatic int model_val(input int code);
`ifdef ADC_MV_SCALE_EN
        return (code * 3300) / 4096;
`else
        return code;
`endif
    endfunction

    // ADC model plus per-clock scoreboard.
    initial begin
        forever begin
            @(posedge clk_50M);
            #1;
            if (!reset_n) begin
                chk("rst_cs_n", adc_cs_n, 1);
                chk("rst_sck", adc_sck, 1);
                chk("rst_din", adc_din, 0);
                chk("rst_in0", in0, 0);
                chk("rst_in1", in1, 0);
                chk("rst_in2", in2, 0);
                chk("rst_dv", data_valid, 0);
                exp_in      = '{0, 0, 0};
                got0        = 0;
                got1        = 0;
                pend        = 0;
                nframe      = 0;
                frames_done = 0;
                dv_count    = 0;
                since       = 0;
                gap_valid   = 0;
                adc_ch      = 0;
                adc_k       = 0;
                adc_addr    = 0;
                adc_dout    = 1'b0;
                f0_din      = 0;
                prev_cs     = 1'b1;
                prev_sck    = 1'b1;
                prev_din    = 1'b0;
                prev_dv     = 1'b0;
                prev_in0    = 0;
                prev_in1    = 0;
            end else begin
                // Result registers and scan pulse
                dv_exp = 0;
                if (pend) begin
                    exp_in[pend_ch] = pend_val;
                    if (pend_ch == 0) got0 = 1;
                    else if (pend_ch == 1) got1 = 1;
                    else if (got0 && got1) begin
                        dv_exp = 1;
                        got0   = 0;
                        got1   = 0;
                    end
                    pend = 0;
                end
                chk("in0", in0, exp_in[0]);
                chk("in1", in1, exp_in[1]);
                chk("in2", in2, exp_in[2]);
                chk("data_valid", data_valid, dv_exp);
                if (data_valid) begin
                    dv_count++;
                    chk("dv_width", prev_dv, 0);
                    chk("dv_in0_stable", in0, prev_in0);
                    chk("dv_in1_stable", in1, prev_in1);
                end

                // Serial interface
                since++;
                cs_fell  = prev_cs && !adc_cs_n;
                cs_rose  = !prev_cs && adc_cs_n;
                sck_fell = prev_sck && !adc_sck;
                sck_rose = !prev_sck && adc_sck;
                if (adc_din !== prev_din) chk("din_on_fall", sck_fell, 1);

                if (cs_fell) begin
                    chk("cs_fall_sck_high", adc_sck, 1);
                    if (gap_valid) chk("gap_len", since, FRAME_GAP * CLK_DIV);
                    since  = 0;
                    adc_k  = 0;
                    cur_ch = nframe % 3;
                    chk("adc_conv_ch", adc_ch, cur_ch);
                    frame_code = codes[adc_ch];
                end else if (!adc_cs_n && (sck_fell || sck_rose)) begin
                    chk("half_period", since, CLK_DIV);
                    since = 0;
                    if (sck_fell) begin
                        if (adc_k < 4) adc_dout = lead_ones ? 1'b1 : 1'($urandom_range(0, 1));
                        else if (adc_k < 16) adc_dout = frame_code[15 - adc_k];
                        else adc_dout = 1'b0;
                    end else begin
                        exp_addr = 3'((nframe + 1) % 3);
                        chk("din_bit", adc_din, (adc_k >= 2 && adc_k <= 4) ? exp_addr[4 - adc_k] : 1'b0);
                        if (nframe == 0 && adc_k < 5) begin
                            f0_din = {f0_din[3:0], adc_din};
                            if (adc_k == 4) chk("first_frame_din", f0_din, 5'b00001);
                        end
                        if (adc_k >= 2 && adc_k <= 4) adc_addr = {adc_addr[1:0], adc_din};
                        adc_k++;
                        if (adc_k == 16) begin
                            pend     = 1;
                            pend_ch  = cur_ch;
                            pend_val = model_val(int'(frame_code));
                        end
                    end
                end else if (cs_rose) begin
                    chk("cs_hold_len", since, CLK_DIV);
                    chk("cs_rise_sck_high", adc_sck, 1);
                    chk("sck_periods", adc_k, 16);
                    if (adc_k == 16) adc_ch = int'(adc_addr);
                    nframe++;
                    frames_done++;
                    gap_valid = 1;
                    since     = 0;
                end else if (adc_cs_n && (sck_fell || sck_rose)) begin
                    chk("sck_quiet_cs_high", adc_sck, prev_sck);
                end

                prev_cs  = adc_cs_n;
                prev_sck = adc_sck;
                prev_din = adc_din;
                prev_dv  = data_valid;
                prev_in0 = in0;
                prev_in1 = in1;
            end
        end
    end

    task automatic wait_dv(input int maxc, input string name);
        bit seen;
        seen = 0;
        for (int n = 0; n < maxc && !seen; n++) begin
            @(posedge clk_50M);
            #2;
            seen = data_valid;
        end
        chk(name, seen, 1);
    endtask

    task automatic wait_cs_low(input int maxc);
        bit seen;
        seen = 0;
        for (int n = 0; n < maxc && !seen; n++) begin
            @(posedge clk_50M);
            #2;
            seen = !adc_cs_n;
        end
        chk("wait_cs_low", seen, 1);
    endtask

    initial begin
        int cyc;
        codes[0]  = 12'h0E0;
        codes[1]  = 12'hAAA;
        codes[2]  = 12'h0E0;
        lead_ones = 1;

        #1 reset_n = 1'b0;
        #1;
        chk("init_cs_n", adc_cs_n, 1);
        chk("init_sck", adc_sck, 1);
        chk("init_dv", data_valid, 0);

        // Pin the reference conversion
        chk("model_0E0", model_val(12'h0E0), E_0E0);
        chk("model_AAA", model_val(12'hAAA), E_AAA);
        chk("model_FFF", model_val(12'hFFF), E_FFF);
        chk("model_000", model_val(12'h000), E_000);
        chk("model_800", model_val(12'h800), E_800);

        repeat (5) @(posedge clk_50M);
        @(negedge clk_50M) reset_n = 1'b1;

        // First scan with ones on the leading bits
        wait_dv(4000, "scan1_timeout");
        chk("scan1_in0", in0, E_0E0);
        chk("scan1_in1", in1, E_AAA);
        chk("scan1_in2", in2, E_0E0);
        codes[0]  = 12'hFFF;
        codes[1]  = 12'h000;
        codes[2]  = 12'h800;
        lead_ones = 0;

        wait_dv(3500, "scan2_timeout");
        chk("scan2_in0", in0, E_FFF);
        chk("scan2_in1", in1, E_000);
        chk("scan2_in2", in2, E_800);

        // Reset in the middle of a frame
        wait_cs_low(2000);
        repeat (300) @(posedge clk_50M);
        #5 reset_n = 1'b0;
        #1;
        chk("arst_cs_n", adc_cs_n, 1);
        chk("arst_sck", adc_sck, 1);
        chk("arst_din", adc_din, 0);
        chk("arst_in0", in0, 0);
        chk("arst_in1", in1, 0);
        chk("arst_in2", in2, 0);
        chk("arst_dv", data_valid, 0);
        repeat (10) @(posedge clk_50M);
        @(negedge clk_50M) reset_n = 1'b1;

        // Steady state with fresh random codes each scan
        cyc = 0;
        while (frames_done < 30 && cyc < 30000) begin
            @(posedge clk_50M);
            #2;
            cyc++;
            if (data_valid) begin
                for (int i = 0; i < 3; i++) codes[i] = 12'($urandom_range(0, 4095));
                lead_ones = 1'($urandom_range(0, 1));
            end
        end
        chk("steady_frames", frames_done, 30);
        chk("steady_dv_pulses", dv_count, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
